wan_time_setter: RTL
====================

Name: wan_time_setter

Overview:
- Front-end that drives the perpetual calendar's load interface: year/mon/week/day/hour/min/sec set values plus the time_set strobe.
- Sits between debounced panel buttons and the calendar counter.
- Snapshots the running time, lets the user edit one field at a time with range and leap-year checks, then commits with a time_set pulse of fixed length.

Parameters:
- TSET_CYCLES, 2, number of clk cycles time_set is held high on commit (must be ≥1).
- TIMEOUT_CYCLES, 600, idle cycles in edit mode before abort without commit; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset on next posedge clk).
- btn_mode  in  1  single-cycle pulse; enter edit / advance to next field.
- btn_inc  in  1  single-cycle pulse; increment selected field.
- btn_dec  in  1  single-cycle pulse; decrement selected field.
- btn_ok  in  1  single-cycle pulse; commit edited values.
- btn_esc  in  1  single-cycle pulse; abort edit, no commit.
- cur_year  in  12  running calendar year, binary.
- cur_mon  in  4  running month.
- cur_week  in  3  running weekday.
- cur_day  in  5  running day.
- cur_hour  in  5  running hour.
- cur_min  in  6  running minute.
- cur_sec  in  6  running second.
- year_set  out  12  working year, range 2000..2199.
- mon_set  out  4  working month, range 1..12.
- week_set  out  3  working weekday, range 1..7.
- day_set  out  5  working day, range 1..dim.
- hour_set  out  5  working hour, range 0..23.
- min_set  out  6  working minute, range 0..59.
- sec_set  out  6  working second, range 0..59.
- time_set  out  1  load strobe to calendar, registered.
- edit_active  out  1  high in any edit or commit state.
- field_sel  out  3  field being edited: 0 none, 1 year, 2 mon, 3 day, 4 week, 5 hour, 6 min, 7 sec.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; year_set=2000, mon_set=1, week_set=6, day_set=1, hour/min/sec_set=0; time_set=0; edit_active=0; field_sel=0; timeout counter=0.
- States: IDLE, E_YEAR, E_MON, E_DAY, E_WEEK, E_HOUR, E_MIN, E_SEC, COMMIT.
- IDLE:
  - btn_mode → E_YEAR.
  - On the same edge, all working registers load cur_* values.
  - Out-of-range cur_* values are loaded unchanged. The first inc or dec on such a field sets it to its minimum value.
  - All other buttons are ignored in IDLE.
- Edit states, button priority per cycle: esc > ok > mode > inc/dec.
  - btn_esc → IDLE; working registers keep their edited values; no time_set.
  - btn_ok → COMMIT.
  - btn_mode → next field in order YEAR, MON, DAY, WEEK, HOUR, MIN, SEC, then back to YEAR.
  - btn_inc and btn_dec in the same cycle → no change.
- Increment/decrement on the selected field, modular:
  - Incrementing at the maximum wraps to the minimum.
  - Decrementing at the minimum wraps to the maximum.
  - Year wraps 2199 → 2000 and 2000 → 2199.
- dim (days in month): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; for month 2, 29 if leap, else 28.
  - Leap year: year[1:0]==0 and year≠2100 (2000 is leap; 2100 is not).
- Day clamp: any change of year or month also updates day_set in the same edge to min(day_set, dim(new year, new month)).
- field_sel equals the current edit state's code. edit_active=1 in all edit states and in COMMIT.
- COMMIT:
  - time_set=1 for exactly TSET_CYCLES consecutive cycles, starting the cycle after btn_ok is sampled, then 0.
  - State returns to IDLE on the edge that deasserts time_set.
  - *_set outputs are stable for the whole pulse and held afterwards.
  - All buttons are ignored during COMMIT.
- Timeout:
  - Counter clears on any button pulse and counts in edit states.
  - When the count reaches TIMEOUT_CYCLES-1 → IDLE with no commit.
  - The counter is inactive in IDLE and COMMIT.
- Reset mid-COMMIT: time_set drops at the reset edge; all outputs take their reset values.

Optional Feature:
- Macro: WAN_TIME_SETTER_BLINK_EN.
- When defined:
  - Adds parameter BLINK_DIV (default 5), an extra output blink (1 bit), and a free-running divider.
  - blink toggles every BLINK_DIV clk cycles while in an edit state.
  - blink forces high and the divider clears on any inc/dec/mode pulse.
  - blink=0 in IDLE, in COMMIT, and after reset.
- When undefined: no blink port and no divider logic.

Test Plan:
- cur = 2099-12-31 w3 23:59:58; mode, inc → year_set=2100; mode, mode (field_sel=3) → day_set stays 31; ok → time_set high exactly 2 cycles with 2100/12/31/3/23/59/58.
- Edit 2000-01-31: year held 2000; at mon press inc → mon_set=2 and day_set=29 on the same edge; set year 2100 → day_set=28.
- In E_SEC with sec_set=0: dec → 59; inc → 0. In E_YEAR: dec from 2000 → 2199. btn_inc+btn_dec in the same cycle → no change.
- Enter edit, change hour, then btn_esc → time_set never asserts; edit_active=0 the next cycle. Same flow with btn_ok+btn_esc in one cycle → esc wins.
- TIMEOUT_CYCLES=8: enter edit, press nothing → return to IDLE after 8 cycles, no time_set. A button press at cycle 5 restarts the count.
- Assert rst=0 during the first time_set cycle → at the next edge time_set=0, year_set=2000, week_set=6, field_sel=0.

Source files
------------

// File: rtl/wan_time_setter_if.sv
// Panel-button / calendar-load bundle for wan_time_setter.
// Master drives buttons and running time; slave returns working values and strobe.
interface wan_time_setter_if;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_ok;
    logic        btn_esc;
    logic [11:0] cur_year;
    logic [3:0]  cur_mon;
    logic [2:0]  cur_week;
    logic [4:0]  cur_day;
    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [11:0] year_set;
    logic [3:0]  mon_set;
    logic [2:0]  week_set;
    logic [4:0]  day_set;
    logic [4:0]  hour_set;
    logic [5:0]  min_set;
    logic [5:0]  sec_set;
    logic        time_set;
    logic        edit_active;
    logic [2:0]  field_sel;

    modport master (
        output btn_mode, btn_inc, btn_dec, btn_ok, btn_esc,
        output cur_year, cur_mon, cur_week, cur_day, cur_hour, cur_min, cur_sec,
        input  year_set, mon_set, week_set, day_set, hour_set, min_set, sec_set,
        input  time_set, edit_active, field_sel
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, btn_ok, btn_esc,
        input  cur_year, cur_mon, cur_week, cur_day, cur_hour, cur_min, cur_sec,
        output year_set, mon_set, week_set, day_set, hour_set, min_set, sec_set,
        output time_set, edit_active, field_sel
    );
endinterface

// File: rtl/wan_time_setter.sv
// Calendar time-set front end: snapshot, per-field edit with leap/day clamp, timed commit strobe.
// Optional cursor blink output enabled by defining WAN_TIME_SETTER_BLINK_EN.
module wan_time_setter #(
    parameter int TSET_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 600
`ifdef WAN_TIME_SETTER_BLINK_EN
    ,
    parameter int BLINK_DIV      = 5
`endif
) (
    input  logic clk,
    input  logic rst,
    wan_time_setter_if.slave bus
`ifdef WAN_TIME_SETTER_BLINK_EN
    ,
    output logic blink
`endif
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        E_YEAR = 4'd1,
        E_MON  = 4'd2,
        E_DAY  = 4'd3,
        E_WEEK = 4'd4,
        E_HOUR = 4'd5,
        E_MIN  = 4'd6,
        E_SEC  = 4'd7,
        COMMIT = 4'd8
    } state_t;

    localparam int TSW = (TSET_CYCLES > 1) ? $clog2(TSET_CYCLES) : 1;
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TSW-1:0] TS_LAST = TSW'((TSET_CYCLES > 0) ? TSET_CYCLES - 1 : 0);
    localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state_reg, state_next;
    logic [11:0]     year_reg, year_next;
    logic [3:0]      mon_reg, mon_next;
    logic [2:0]      week_reg, week_next;
    logic [4:0]      day_reg, day_next;
    logic [4:0]      hour_reg, hour_next;
    logic [5:0]      min_reg, min_next;
    logic [5:0]      sec_reg, sec_next;
    logic [TSW-1:0]  ts_cnt_reg, ts_cnt_next;
    logic [TOW-1:0]  to_cnt_reg, to_cnt_next;
    logic            time_set_reg;
    logic [3:0]      state_code;
    logic            any_btn, step_up, step_dn;
    logic [4:0]      dim_new;

    function automatic logic [4:0] dim(input logic [11:0] y, input logic [3:0] m);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:    return (y[1:0] == 2'b00 && y != 12'd2100) ? 5'd29 : 5'd28;
            default: return 5'd31;
        endcase
    endfunction

    // Out-of-range values snap to the minimum on their first step.
    function automatic logic [11:0] step_val(input logic [11:0] v, input logic [11:0] lo,
                                             input logic [11:0] hi, input logic up);
        if (v < lo || v > hi) return lo;
        if (up) return (v == hi) ? lo : v + 12'd1;
        return (v == lo) ? hi : v - 12'd1;
    endfunction

    assign state_code = state_reg;
    assign any_btn    = bus.btn_mode | bus.btn_inc | bus.btn_dec | bus.btn_ok | bus.btn_esc;
    assign step_up    = bus.btn_inc & ~bus.btn_dec;
    assign step_dn    = bus.btn_dec & ~bus.btn_inc;

    always_comb begin
        state_next  = state_reg;
        year_next   = year_reg;
        mon_next    = mon_reg;
        week_next   = week_reg;
        day_next    = day_reg;
        hour_next   = hour_reg;
        min_next    = min_reg;
        sec_next    = sec_reg;
        ts_cnt_next = ts_cnt_reg;
        to_cnt_next = to_cnt_reg;
        dim_new     = 5'd31;
        case (state_reg)
            IDLE: begin
                if (bus.btn_mode) begin
                    state_next  = E_YEAR;
                    year_next   = bus.cur_year;
                    mon_next    = bus.cur_mon;
                    week_next   = bus.cur_week;
                    day_next    = bus.cur_day;
                    hour_next   = bus.cur_hour;
                    min_next    = bus.cur_min;
                    sec_next    = bus.cur_sec;
                    to_cnt_next = '0;
                end
            end
            COMMIT: begin
                if (ts_cnt_reg == TS_LAST) begin
                    state_next  = IDLE;
                    ts_cnt_next = '0;
                end else begin
                    ts_cnt_next = ts_cnt_reg + 1'b1;
                end
            end
            E_YEAR, E_MON, E_DAY, E_WEEK, E_HOUR, E_MIN, E_SEC: begin
                if (any_btn) begin
                    to_cnt_next = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (to_cnt_reg == TO_LAST) begin
                        state_next  = IDLE;
                        to_cnt_next = '0;
                    end else begin
                        to_cnt_next = to_cnt_reg + 1'b1;
                    end
                end

                if (bus.btn_esc) begin
                    state_next = IDLE;
                end else if (bus.btn_ok) begin
                    state_next  = COMMIT;
                    ts_cnt_next = '0;
                end else if (bus.btn_mode) begin
                    state_next = (state_reg == E_SEC) ? E_YEAR : state_t'(state_code + 4'd1);
                end else if (step_up || step_dn) begin
                    case (state_reg)
                        E_YEAR: year_next = step_val(year_reg, 12'd2000, 12'd2199, step_up);
                        E_MON:  mon_next  = 4'(step_val(12'(mon_reg), 12'd1, 12'd12, step_up));
                        E_DAY:  day_next  = 5'(step_val(12'(day_reg), 12'd1,
                                                        12'(dim(year_reg, mon_reg)), step_up));
                        E_WEEK: week_next = 3'(step_val(12'(week_reg), 12'd1, 12'd7, step_up));
                        E_HOUR: hour_next = 5'(step_val(12'(hour_reg), 12'd0, 12'd23, step_up));
                        E_MIN:  min_next  = 6'(step_val(12'(min_reg), 12'd0, 12'd59, step_up));
                        default: sec_next = 6'(step_val(12'(sec_reg), 12'd0, 12'd59, step_up));
                    endcase
                    // Year or month change pulls the day down into the new month.
                    if (state_reg == E_YEAR || state_reg == E_MON) begin
                        dim_new = dim(year_next, mon_next);
                        if (day_reg > dim_new) day_next = dim_new;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            year_reg     <= 12'd2000;
            mon_reg      <= 4'd1;
            week_reg     <= 3'd6;
            day_reg      <= 5'd1;
            hour_reg     <= '0;
            min_reg      <= '0;
            sec_reg      <= '0;
            ts_cnt_reg   <= '0;
            to_cnt_reg   <= '0;
            time_set_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            year_reg     <= year_next;
            mon_reg      <= mon_next;
            week_reg     <= week_next;
            day_reg      <= day_next;
            hour_reg     <= hour_next;
            min_reg      <= min_next;
            sec_reg      <= sec_next;
            ts_cnt_reg   <= ts_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            time_set_reg <= (state_next == COMMIT);
        end
    end

    assign bus.year_set    = year_reg;
    assign bus.mon_set     = mon_reg;
    assign bus.week_set    = week_reg;
    assign bus.day_set     = day_reg;
    assign bus.hour_set    = hour_reg;
    assign bus.min_set     = min_reg;
    assign bus.sec_set     = sec_reg;
    assign bus.time_set    = time_set_reg;
    assign bus.edit_active = (state_reg != IDLE);
    assign bus.field_sel   = state_code[3] ? 3'd0 : state_code[2:0];

`ifdef WAN_TIME_SETTER_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_DIV > 0) ? BLINK_DIV - 1 : 0);

    logic          blink_reg;
    logic [BW-1:0] div_reg;
    logic          next_edit;

    assign next_edit = (state_next != IDLE) && (state_next != COMMIT);

    always_ff @(posedge clk) begin
        if (!rst || !next_edit) begin
            blink_reg <= 1'b0;
            div_reg   <= '0;
        end else if (bus.btn_inc || bus.btn_dec || bus.btn_mode) begin
            blink_reg <= 1'b1;
            div_reg   <= '0;
        end else if (div_reg == BLINK_LAST) begin
            blink_reg <= ~blink_reg;
            div_reg   <= '0;
        end else begin
            div_reg   <= div_reg + 1'b1;
        end
    end

    assign blink = blink_reg;
`endif

endmodule
